// File: rtl/billing_ctrl.sv
// billing_ctrl: per-mode price freeze, grace countdown, idle-spin fine accrual and signed balance commit.
// Ports: clk, rst (async active-low), on (clock enable/hold), m_pos/u_pos/d_pos (confirm/unload/finish pulses),
//   mode, bal, price_tbl (packed NMODE x W), fine -> st, charge, new_bal, neg, bal_we, next, wt_light, st_light.
// Macro BILLING_FINE_EN: enables the FINE state; undefined, the expiring grace tick auto-commits.
module billing_ctrl #(
   parameter int NMODE = 4,
   parameter int W     = 12,
   parameter int TICK  = 100000000,
   parameter int GRACE = 8,
   parameter int LAMP  = 8
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       on,
   input  logic                       m_pos,
   input  logic                       u_pos,
   input  logic                       d_pos,
   input  logic [$clog2(NMODE)-1:0]   mode,
   input  logic [W-1:0]               bal,
   input  logic [NMODE*W-1:0]         price_tbl,
   input  logic [W-1:0]               fine,
   output logic [1:0]                 st,
   output logic [W-1:0]               charge,
   output logic [W-1:0]               new_bal,
   output logic                       neg,
   output logic                       bal_we,
   output logic                       next,
   output logic [LAMP-1:0]            wt_light,
   output logic [7:0]                 st_light
);
   localparam int TW = TICK > 1 ? $clog2(TICK) : 1;
   localparam int CW = $clog2(GRACE + 1);
   typedef enum logic [1:0] {S_IDLE = 2'b00, S_GRACE = 2'b01, S_FINE = 2'b10, S_DONE = 2'b11} state_t;
   state_t s, s_n;
   logic [TW-1:0] t, t_n;
   logic [CW-1:0] cd, cd_n;
   logic [W-1:0] acc, acc_n, price, price_n, charge_n, new_bal_n, sel;
   logic [LAMP-1:0] wt_n;
   logic [7:0] stl_n;
   logic neg_n, we_n, next_n, tick, expire, commit;
   logic [W:0] acc_sum, chg_sum;
   logic signed [W+1:0] d, mag;

   function automatic logic [LAMP-1:0] bar(input int c);
      for (int i = 0; i < LAMP; i++) bar[i] = c > i;
   endfunction

   assign st = s;

   always_comb begin
      sel = '0;
      for (int k = 0; k < NMODE; k++) if (int'(mode) == k) sel = price_tbl[k*W +: W];
      tick = t == TW'(TICK - 1);
      expire = tick && cd == CW'(1);
      acc_sum = {1'b0, acc} + {1'b0, fine};
      // W+2 signed bits cover bal - price - acc over the full unsigned input range
      d = $signed({2'b00, bal}) - $signed({2'b00, price}) - $signed({2'b00, acc});
      mag = d[W+1] ? -d : d;
      commit = 1'b0;
      s_n = s;
      t_n = t;
      cd_n = cd;
      acc_n = acc;
      price_n = price;
      charge_n = charge;
      new_bal_n = new_bal;
      neg_n = neg;
      we_n = 1'b0;
      next_n = 1'b0;
      case (s)
         S_IDLE: begin
            charge_n = sel;
            if (m_pos) begin
               s_n = S_GRACE;
               t_n = '0;
               cd_n = CW'(GRACE);
               acc_n = '0;
               price_n = sel;
            end
         end
         S_GRACE: begin
            t_n = tick ? '0 : t + 1'b1;
            cd_n = tick ? cd - 1'b1 : cd;
`ifdef BILLING_FINE_EN
            s_n = expire ? S_FINE : s;
            commit = u_pos;
`else
            commit = u_pos | expire;
`endif
         end
         S_FINE: begin
            t_n = tick ? '0 : t + 1'b1;
            acc_n = tick ? (acc_sum[W] ? '1 : acc_sum[W-1:0]) : acc;
            commit = u_pos;
         end
         default: if (d_pos) begin
            s_n = S_IDLE;
            next_n = 1'b1;
            cd_n = CW'(GRACE);
            t_n = '0;
         end
      endcase
      // a commit overrides any tick landing in the same cycle: the fine of that tick is dropped
      if (commit) begin
         s_n = S_DONE;
         t_n = '0;
         acc_n = acc;
         we_n = 1'b1;
         neg_n = d[W+1];
         new_bal_n = |mag[W+1:W] ? '1 : mag[W-1:0];
      end
      chg_sum = {1'b0, price} + {1'b0, acc_n};
      if (s == S_FINE) charge_n = chg_sum[W] ? '1 : chg_sum[W-1:0];
      wt_n = s_n == S_FINE ? '0 : bar(int'(cd_n));
      stl_n = s_n == S_IDLE ? 8'h40 : s_n == S_GRACE ? 8'h80 : s_n == S_FINE ? 8'h20 : 8'h10;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         s <= S_IDLE;
         t <= '0;
         cd <= CW'(GRACE);
         acc <= '0;
         price <= '0;
         charge <= '0;
         new_bal <= '0;
         neg <= 1'b0;
         bal_we <= 1'b0;
         next <= 1'b0;
         wt_light <= bar(GRACE);
         st_light <= 8'h40;
      end else if (on) begin
         s <= s_n;
         t <= t_n;
         cd <= cd_n;
         acc <= acc_n;
         price <= price_n;
         charge <= charge_n;
         new_bal <= new_bal_n;
         neg <= neg_n;
         bal_we <= we_n;
         next <= next_n;
         wt_light <= wt_n;
         st_light <= stl_n;
      end
   end
endmodule

// File: tb/tb_billing_ctrl.sv
// tb_billing_ctrl: directed bench for billing_ctrl with a commit scoreboard.
module tb_billing_ctrl;
   localparam int NMODE = 4, W = 12, TICK = 4, GRACE = 3, LAMP = 8;
   typedef struct {logic n; logic [W-1:0] v;} exp_t;
   logic clk = 0, rst = 1, on = 1, m_pos = 0, u_pos = 0, d_pos = 0;
   logic [1:0] mode = 0;
   logic [W-1:0] bal = 0, fine = 12'd5;
   logic [NMODE*W-1:0] price_tbl = {12'd40, 12'd30, 12'd20, 12'd10};
   logic [1:0] st;
   logic [W-1:0] charge, new_bal;
   logic neg, bal_we, next;
   logic [LAMP-1:0] wt_light;
   logic [7:0] st_light;
   int checks = 0, errors = 0, we_count = 0;
   exp_t sb[$];
   exp_t e;

   billing_ctrl #(.NMODE(NMODE), .W(W), .TICK(TICK), .GRACE(GRACE), .LAMP(LAMP)) dut (
      .clk(clk), .rst(rst), .on(on), .m_pos(m_pos), .u_pos(u_pos), .d_pos(d_pos),
      .mode(mode), .bal(bal), .price_tbl(price_tbl), .fine(fine),
      .st(st), .charge(charge), .new_bal(new_bal), .neg(neg), .bal_we(bal_we),
      .next(next), .wt_light(wt_light), .st_light(st_light)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step(input int n = 1);
      repeat (n) @(negedge clk);
   endtask

   task automatic pulse_m();
      m_pos = 1;
      step();
      m_pos = 0;
   endtask

   task automatic pulse_d();
      d_pos = 1;
      step();
      d_pos = 0;
      chk("next_pulse", next, 1);
      chk("st_idle", st, 0);
      chk("stl_idle", st_light, 8'h40);
      step();
      chk("next_single", next, 0);
   endtask

   always @(negedge clk) if (bal_we === 1'b1) begin
      we_count++;
      chk("sb_pending", 32'(sb.size() != 0), 1);
      if (sb.size() != 0) begin
         e = sb.pop_front();
         chk("sb_new_bal", new_bal, e.v);
         chk("sb_neg", neg, e.n);
      end
   end

   initial begin
      #100000;
      $display("FAIL timeout: bench did not finish");
      $fatal(1);
   end

   initial begin
      #1 rst = 0;
      #3;
      chk("rst_st", st, 0);
      chk("rst_charge", charge, 0);
      chk("rst_new_bal", new_bal, 0);
      chk("rst_neg", neg, 0);
      chk("rst_bal_we", bal_we, 0);
      chk("rst_next", next, 0);
      chk("rst_wt", wt_light, 8'b0000_0111);
      chk("rst_stl", st_light, 8'h40);
      step();
      rst = 1;
      step();
      chk("idle_charge_m0", charge, 10);
      // price select and commit
      mode = 2;
      bal = 100;
      step();
      chk("idle_charge_m2", charge, 30);
      pulse_m();
      chk("grace_st", st, 1);
      chk("grace_wt", wt_light, 8'b111);
      chk("grace_stl", st_light, 8'h80);
      mode = 0;
      step(4);
      chk("grace_wt_tick1", wt_light, 8'b011);
      chk("frozen_charge", charge, 30);
      u_pos = 1;
      sb.push_back('{1'b0, 12'd70});
      step();
      u_pos = 0;
      chk("commit_we", bal_we, 1);
      chk("commit_st", st, 3);
      chk("commit_stl", st_light, 8'h10);
      chk("commit_bal", new_bal, 70);
      step();
      chk("we_single", bal_we, 0);
      chk("done_charge", charge, 30);
      pulse_d();
      chk("idle_retrack", charge, 10);
      // debt
      mode = 3;
      bal = 25;
      step();
      chk("idle_charge_m3", charge, 40);
      pulse_m();
      u_pos = 1;
      sb.push_back('{1'b1, 12'd15});
      step();
      u_pos = 0;
      chk("debt_neg", neg, 1);
      chk("debt_bal", new_bal, 15);
      pulse_m();
      chk("done_ignores_m", st, 3);
      pulse_d();
`ifdef BILLING_FINE_EN
      // fine accrual
      mode = 1;
      bal = 100;
      step();
      pulse_m();
      step(11);
      chk("pre_fine_wt", wt_light, 8'b001);
      step();
      chk("fine_st", st, 2);
      chk("fine_stl", st_light, 8'h20);
      chk("fine_wt", wt_light, 0);
      chk("fine_charge0", charge, 20);
      step(8);
      chk("fine_charge2", charge, 30);
      u_pos = 1;
      sb.push_back('{1'b0, 12'd70});
      step();
      u_pos = 0;
      chk("fine_commit_st", st, 3);
      chk("fine_commit_charge", charge, 30);
      pulse_d();
      // collision: u_pos on the expiring grace tick
      mode = 2;
      step();
      pulse_m();
      step(11);
      u_pos = 1;
      sb.push_back('{1'b0, 12'd70});
      step();
      u_pos = 0;
      chk("coll_st", st, 3);
      chk("coll_we", bal_we, 1);
      chk("coll_charge", charge, 30);
      pulse_d();
`else
      // automatic commit on the expiring grace tick
      mode = 2;
      bal = 100;
      step();
      pulse_m();
      sb.push_back('{1'b0, 12'd70});
      for (int i = 1; i <= 11; i++) begin
         step();
         chk("no_early_we", bal_we, 0);
         chk("no_early_st", st, 1);
      end
      step();
      chk("auto_we", bal_we, 1);
      chk("auto_st", st, 3);
      chk("auto_bal", new_bal, 70);
      step();
      chk("auto_we_single", bal_we, 0);
      pulse_d();
`endif
      // freeze with on=0
      mode = 0;
      bal = 50;
      step();
      pulse_m();
      step(2);
      on = 0;
      u_pos = 1;
      step();
      u_pos = 0;
      step(9);
      chk("frz_st", st, 1);
      chk("frz_wt", wt_light, 8'b111);
      chk("frz_we", bal_we, 0);
      on = 1;
      step();
      chk("frz_t_kept", wt_light, 8'b111);
      step();
      chk("frz_tick", wt_light, 8'b011);
`ifdef BILLING_FINE_EN
      step(8);
      chk("pre_rst_fine", st, 2);
`endif
      // asynchronous reset mid-operation
      #2 rst = 0;
      u_pos = 1;
      #1;
      chk("arst_st", st, 0);
      chk("arst_charge", charge, 0);
      chk("arst_new_bal", new_bal, 0);
      chk("arst_neg", neg, 0);
      chk("arst_we", bal_we, 0);
      chk("arst_next", next, 0);
      chk("arst_wt", wt_light, 8'b111);
      chk("arst_stl", st_light, 8'h40);
      step();
      u_pos = 0;
      rst = 1;
      step(3);
      chk("arst_idle", st, 0);
`ifdef BILLING_FINE_EN
      chk("we_total", we_count, 4);
`else
      chk("we_total", we_count, 3);
`endif
      chk("sb_drained", sb.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/billing_ctrl.md
# billing_ctrl

Parametrised billing controller for the washing-machine top level. It sits between the mode/price selection and the balance register. It selects a per-mode price from a packed table and freezes it on confirm. It then runs a grace countdown, accrues an idle-spin fine per second after the grace period expires, and commits the final signed balance to the balance register with a one-cycle write strobe. Display formatting and digit scanning are handled downstream.

## Interface
- NMODE, 4: number of wash programs (≥2)
- W, 12: width of balance, price and fine values (binary, unsigned)
- TICK, 100000000: clk cycles per billing second
- GRACE, 8: grace-period seconds after confirm
- LAMP, 8: width of the countdown lamp bar
- clk  in  1  system clock, all state on rising edge
- rst  in  1  asynchronous active-low reset
- on  in  1  machine power; when 0, every register holds its value
- m_pos  in  1  confirm pulse (one cycle, debounced upstream)
- u_pos  in  1  unload pulse
- d_pos  in  1  door-closed/finish pulse
- mode  in  clog2(NMODE)  selected program
- bal  in  W  current account balance
- price_tbl  in  NMODE*W  packed prices; entry k = bits [k*W +: W]
- fine  in  W  fine per elapsed second
- st  out  2  state: 00 IDLE, 01 GRACE, 10 FINE, 11 DONE
- charge  out  W  frozen price plus accrued fine
- new_bal  out  W  magnitude of committed balance
- neg  out  1  committed balance is negative (debt)
- bal_we  out  1  one-cycle commit strobe
- next  out  1  one-cycle handoff pulse to the wash sequencer
- wt_light  out  LAMP  countdown thermometer
- st_light  out  8  status lamps

## Operation
- Reset values:
  - st=IDLE, t=0, cd=GRACE, acc=0, charge=0, new_bal=0
  - neg=0, bal_we=0, next=0
  - wt_light all ones when GRACE≥LAMP; st_light=8'h40
- on=0 takes priority over all inputs: no state, counter or output change. Pulses arriving while on=0 are lost.
- IDLE:
  - charge tracks price_tbl[mode] every cycle; charge=0 when mode≥NMODE.
  - m_pos: t←0, cd←GRACE, acc←0, st←GRACE. The charge value is frozen at this point.
- GRACE:
  - The tick fires when t==TICK-1; t then wraps to 0.
  - Each tick decrements cd.
  - When a tick takes cd from 1 to 0, st←FINE.
- FINE:
  - Each tick sets acc←acc+fine, saturating at 2^W-1.
  - charge shows price+acc, saturated to W bits.
- Commit (u_pos in GRACE or FINE):
  - d = bal − price − acc, computed signed at W+2 bits.
  - neg←(d<0); new_bal←|d|, saturated to 2^W-1.
  - bal_we=1 for exactly one cycle; st←DONE; t←0.
- DONE: d_pos → next=1 for one cycle, st←IDLE, cd←GRACE. m_pos and u_pos are ignored in DONE.
- Simultaneous events:
  - u_pos on the same cycle as the expiring GRACE tick: the commit wins, no fine is charged, st←DONE.
  - u_pos on the same cycle as a FINE tick: that tick's fine is not added.
- wt_light bit i = (cd > i), LSB first; all zero once in FINE.
- st_light: IDLE 8'h40, GRACE 8'h80, FINE 8'h20, DONE 8'h10.
- m_pos in GRACE or FINE is ignored; price changes in those states have no effect.

## Timing
- All outputs are registered.
- bal_we, new_bal and neg update on the edge after the cycle in which u_pos is sampled.
- next asserts on the edge after the cycle in which d_pos is sampled.
- First GRACE tick occurs TICK cycles after the m_pos edge. FINE is entered GRACE×TICK cycles after m_pos.
- Async reset mid-operation: all registers return to reset values immediately, and no bal_we is issued.
- The tick counter resets on every state entry.

## Configuration
- BILLING_FINE_EN defined: behaviour exactly as above.
- Undefined:
  - The FINE state is never entered and acc stays 0.
  - The expiring GRACE tick performs an automatic commit (d = bal − price) and goes to DONE; bal_we pulses exactly as for u_pos.
  - st_light value 8'h20 never occurs.

## Test plan
- Parameters TICK=4, GRACE=3, W=12, NMODE=4, price_tbl={40,30,20,10}, fine=5.
- Price select and commit: mode=2, bal=100, m_pos, u_pos after 5 cycles → charge=30, new_bal=70, neg=0, one bal_we pulse, st=DONE.
- Fine accrual (macro on): mode=1, bal=100, m_pos, wait 12+8 cycles, u_pos → 2 fine ticks, new_bal=70, charge=30.
- Debt: mode=3, bal=25, m_pos, u_pos → neg=1, new_bal=15. Then d_pos → single-cycle next, st=IDLE.
- Collision: u_pos on the expiring GRACE tick → no fine, st=DONE. Macro off: no u_pos → auto commit at cycle 12, bal_we pulses once.
- Freeze and reset: on=0 for 10 cycles in GRACE → cd and t unchanged. rst low in FINE → all outputs at reset values, bal_we never asserted.
